// File: rtl/update_filter.sv
// Four-lane compaction stage: left-packs valid update words into slots 0..n-1
// and emits a thermometer valid mask (MSB = slot 0), one registered cycle later.
module update_filter #(
  parameter int LANES  = 4,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              last_input_in,
  input  logic [LANES-1:0]  word_in_valid,
  input  logic [WORD_W-1:0] word_in [LANES-1:0],
  output logic              last_input_out,
  output logic [LANES-1:0]  word_out_valid,
  output logic [WORD_W-1:0] word_out [LANES-1:0]
);

  localparam int CNT_W = $clog2(LANES + 1);

  // Number of set bits in mask strictly below position k.
  function automatic logic [CNT_W-1:0] count_below(input logic [LANES-1:0] mask,
                                                   input int k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < k && mask[i]) c = c + 1'b1;
    end
    return c;
  endfunction

  logic [CNT_W-1:0]  rank      [LANES-1:0];
  logic [CNT_W-1:0]  valid_cnt;
  logic [WORD_W-1:0] word_d    [LANES-1:0];
  logic [WORD_W-1:0] word_q    [LANES-1:0];
  logic [LANES-1:0]  valid_d;
  logic [LANES-1:0]  valid_q;
  logic              last_d;
  logic              last_q;

  genvar gi;

  // A valid lane's rank is the output slot it lands in.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_rank
      assign rank[gi] = count_below(word_in_valid, gi);
    end
  endgenerate

  assign valid_cnt = count_below(word_in_valid, LANES);

  // Each slot picks the unique valid lane whose rank equals the slot index;
  // slots with no such lane stay zero.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_slot
      always_comb begin
        word_d[gi] = '0;
        for (int k = 0; k < LANES; k++) begin
          if (word_in_valid[k] && (rank[k] == CNT_W'(gi))) begin
            word_d[gi] = word_in[k];
          end
        end
      end
    end
  endgenerate

  // Slot j is qualified by bit LANES-1-j.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_therm
      assign valid_d[LANES-1-gi] = (valid_cnt > CNT_W'(gi));
    end
  endgenerate

  assign last_d = last_input_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_word_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          word_q[gi] <= '0;
        end else begin
          word_q[gi] <= word_d[gi];
        end
      end
      assign word_out[gi] = word_q[gi];
    end
  endgenerate

  assign word_out_valid = valid_q;
  assign last_input_out = last_q;

endmodule

// File: tb/tb_update_filter.sv
// Self-checking bench for update_filter: directed scenarios plus random
// masks/words compared against a queue-based compaction model.
module tb_update_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        last_in;
  logic [3:0]  vin;
  logic [63:0] win  [3:0];
  logic        last_out;
  logic [3:0]  vout;
  logic [63:0] wout [3:0];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0]  exp_v;
  logic [63:0] exp_w [3:0];

  always #5 clk = ~clk;

  update_filter #(.LANES(4), .WORD_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .last_input_in  (last_in),
    .word_in_valid  (vin),
    .word_in        (win),
    .last_input_out (last_out),
    .word_out_valid (vout),
    .word_out       (wout)
  );

  // Reference: gather valid words in ascending lane order, pad with zeros;
  // the mask has one leading 1 per valid word, counted from the MSB.
  function automatic void model(input logic [3:0] m);
    logic [63:0] q[$];
    logic [3:0]  therm [0:4];
    therm[0] = 4'b0000; therm[1] = 4'b1000; therm[2] = 4'b1100;
    therm[3] = 4'b1110; therm[4] = 4'b1111;
    q = {};
    for (int k = 0; k < 4; k++) if (m[k]) q.push_back(win[k]);
    for (int j = 0; j < 4; j++) exp_w[j] = (j < q.size()) ? q[j] : 64'h0;
    exp_v = therm[q.size()];
  endfunction

  task automatic test_reset();
    rst = 1'b1; last_in = 1'b1; vin = 4'hF;
    for (int k = 0; k < 4; k++) win[k] = {$urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (vout !== 4'b0000) $display("FAIL reset_valid cyc%0d got %b want 0000", c, vout);
      else pass_cnt++;
      total_cnt++;
      if (last_out !== 1'b0) $display("FAIL reset_last cyc%0d got %b want 0", c, last_out);
      else pass_cnt++;
      for (int j = 0; j < 4; j++) begin
        total_cnt++;
        if (wout[j] !== 64'h0) $display("FAIL reset_word%0d cyc%0d got %h want 0", j, c, wout[j]);
        else pass_cnt++;
      end
    end
    rst = 1'b0; last_in = 1'b0; vin = 4'h0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_single_lane();
    logic [63:0] want [3:0];
    for (int k = 0; k < 4; k++) win[k] = 64'hDEAD_0000 + k;
    win[2] = 64'hAAAA; vin = 4'b0100;
    want[0] = 64'hAAAA; want[1] = 0; want[2] = 0; want[3] = 0;
    @(posedge clk); #1;
    total_cnt++;
    if (vout !== 4'b1000) $display("FAIL single_valid got %b want 1000", vout);
    else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if (wout[j] !== want[j]) $display("FAIL single_word%0d got %h want %h", j, wout[j], want[j]);
      else pass_cnt++;
    end
    $display("test_single_lane mask=0100 out=%b", vout);
  endtask

  task automatic test_sparse_pair();
    logic [63:0] want [3:0];
    win[0] = 64'hBAD0; win[1] = 64'h11; win[2] = 64'hBAD2; win[3] = 64'h33;
    vin = 4'b1010;
    want[0] = 64'h11; want[1] = 64'h33; want[2] = 0; want[3] = 0;
    @(posedge clk); #1;
    total_cnt++;
    if (vout !== 4'b1100) $display("FAIL sparse_valid got %b want 1100", vout);
    else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if (wout[j] !== want[j]) $display("FAIL sparse_word%0d got %h want %h", j, wout[j], want[j]);
      else pass_cnt++;
    end
    $display("test_sparse_pair mask=1010 out=%b", vout);
  endtask

  task automatic test_exhaustive();
    logic [3:0]  pv;
    logic [63:0] pw [3:0];
    for (int k = 0; k < 4; k++) win[k] = 64'h100 + k;
    for (int m = 0; m < 16; m++) begin
      vin = m[3:0];
      model(vin);
      pv = exp_v;
      for (int j = 0; j < 4; j++) pw[j] = exp_w[j];
      @(posedge clk); #1;
      total_cnt++;
      if (vout !== pv) $display("FAIL exh_valid mask=%b got %b want %b", m[3:0], vout, pv);
      else pass_cnt++;
      for (int j = 0; j < 4; j++) begin
        total_cnt++;
        if (wout[j] !== pw[j]) $display("FAIL exh_word%0d mask=%b got %h want %h", j, m[3:0], wout[j], pw[j]);
        else pass_cnt++;
      end
      $display("test_exhaustive mask=%b out=%b", m[3:0], vout);
    end
  endtask

  task automatic test_end_of_stream();
    for (int k = 0; k < 4; k++) win[k] = {$urandom, $urandom};
    vin = 4'b0111; last_in = 1'b1;
    model(vin);
    @(posedge clk); #1;
    last_in = 1'b0; vin = 4'b0000;
    total_cnt++;
    if (vout !== 4'b1110) $display("FAIL eos_valid got %b want 1110", vout);
    else pass_cnt++;
    total_cnt++;
    if (last_out !== 1'b1) $display("FAIL eos_last got %b want 1", last_out);
    else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if (wout[j] !== exp_w[j]) $display("FAIL eos_word%0d got %h want %h", j, wout[j], exp_w[j]);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total_cnt++;
    if (last_out !== 1'b0 || vout !== 4'b0000)
      $display("FAIL eos_after got last=%b valid=%b want 0/0000", last_out, vout);
    else pass_cnt++;
    $display("test_end_of_stream done");
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 4; k++) win[k] = {$urandom, $urandom};
    vin = 4'b1111;
    @(posedge clk); #1;
    total_cnt++;
    if (vout !== 4'b1111) $display("FAIL mid_pre valid got %b want 1111", vout);
    else pass_cnt++;
    rst = 1'b1; last_in = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (vout !== 4'b0000 || last_out !== 1'b0 || wout[0] !== 64'h0 || wout[3] !== 64'h0)
      $display("FAIL mid_rst got valid=%b last=%b w0=%h w3=%h want 0000/0/0/0",
               vout, last_out, wout[0], wout[3]);
    else pass_cnt++;
    rst = 1'b0; last_in = 1'b0; vin = 4'b0000;
    @(posedge clk); #1;
    total_cnt++;
    if (vout !== 4'b0000 || last_out !== 1'b0 || wout[0] !== 64'h0)
      $display("FAIL mid_after got valid=%b last=%b w0=%h want 0000/0/0", vout, last_out, wout[0]);
    else pass_cnt++;
    $display("test_reset_midstream done");
  endtask

  // Inputs change mid-cycle; registered outputs must not follow them.
  task automatic test_no_comb_path();
    logic [3:0] held;
    for (int k = 0; k < 4; k++) win[k] = {$urandom, $urandom};
    vin = 4'b0001;
    @(posedge clk); #1;
    held = vout;
    vin = 4'b1111; last_in = 1'b1;
    win[0] = 64'h5555;
    #2;
    total_cnt++;
    if (vout !== 4'b1000 || held !== 4'b1000 || wout[0] === 64'h5555 || last_out !== 1'b0)
      $display("FAIL comb_path got valid=%b held=%b w0=%h last=%b want 1000/1000/not5555/0",
               vout, held, wout[0], last_out);
    else pass_cnt++;
    last_in = 1'b0;
    $display("test_no_comb_path done");
  endtask

  task automatic test_random();
    logic [3:0]  pv;
    logic        pl;
    logic [63:0] pw [3:0];
    for (int t = 0; t < 200; t++) begin
      vin = 4'($urandom_range(0, 15));
      last_in = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) win[k] = {$urandom, $urandom};
      model(vin);
      pv = exp_v; pl = last_in;
      for (int j = 0; j < 4; j++) pw[j] = exp_w[j];
      @(posedge clk); #1;
      total_cnt++;
      if (vout !== pv || last_out !== pl || wout[0] !== pw[0] || wout[1] !== pw[1] ||
          wout[2] !== pw[2] || wout[3] !== pw[3])
        $display("FAIL rand t=%0d mask=%b got v=%b l=%b %h %h %h %h want v=%b l=%b %h %h %h %h",
                 t, vin, vout, last_out, wout[0], wout[1], wout[2], wout[3],
                 pv, pl, pw[0], pw[1], pw[2], pw[3]);
      else pass_cnt++;
      $display("test_random t=%0d mask=%b out=%b last=%b", t, vin, vout, last_out);
    end
    last_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; last_in = 1'b0; vin = 4'h0;
    for (int k = 0; k < 4; k++) win[k] = 64'h0;
    test_reset();
    test_single_lane();
    test_sparse_pair();
    test_exhaustive();
    test_end_of_stream();
    test_reset_midstream();
    test_no_comb_path();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/update_filter.md
# update_filter

Four-lane compaction stage for SSSP edge-update traffic. It sits between the four per-lane `sssp_pipeline` instances and the 512-bit update-line packer. Each cycle it takes up to four 64-bit update words with an arbitrary valid mask. It emits them left-packed into slots 0..n-1 with a thermometer-coded valid mask, one cycle later.

## Interface
Parameters:
- `LANES`, default 4: number of input/output lanes. Only 4 is supported.
- `WORD_W`, default 64: update word width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `last_input_in`  in  1: end-of-stream marker, taken from lane 0 of the pipelines.
- `word_in_valid`  in  4: bit k qualifies `word_in[k]`; any of the 16 patterns is legal.
- `word_in`  in  4 x 64 (unpacked array [3:0]): per-lane update words.
- `last_input_out`  out  1: `last_input_in` delayed to align with outputs.
- `word_out_valid`  out  4: thermometer mask from the MSB.
- `word_out`  out  4 x 64 (unpacked array [3:0]): compacted words; slot 0 is filled first.

## Operation
- Let n = popcount(`word_in_valid`), 0..4.
- Slot mapping: `word_out[j]`, for j < n, is the j-th valid input in ascending lane order (lane 0 first).
  - Example: mask 4'b1010 gives `word_out[0]`=`word_in[1]` and `word_out[1]`=`word_in[3]`.
- `word_out_valid` encoding:
  - n=0 → 4'b0000
  - n=1 → 4'b1000
  - n=2 → 4'b1100
  - n=3 → 4'b1110
  - n=4 → 4'b1111
- Bit 3 qualifies slot 0, bit 2 slot 1, bit 1 slot 2, bit 0 slot 3. No other output patterns ever occur; downstream treats any other pattern as fatal.
- Unused slots (j ≥ n) are driven to 64'h0.
- Word contents pass through unmodified. No words are dropped, duplicated or reordered beyond the compaction.
- `last_input_out` is `last_input_in` registered.
  - Words presented in the same cycle as `last_input_in`=1 are still compacted and output normally.
  - Their `last_input_out` is asserted in the same output cycle.
- No backpressure. The block accepts a new input set every cycle, unconditionally.

## Timing
- Latency is exactly 1 clock for all outputs. Inputs sampled at edge t appear on the outputs after edge t, held until edge t+1.
- The block is fully pipelined: throughput is 1 input set per cycle.
- All outputs are registered; there are no combinational input→output paths.
- Reset values, all applied at the first clock edge with `rst`=1:
  - `word_out_valid`=4'b0000
  - `word_out` all zero
  - `last_input_out`=0
- Reset mid-stream: the in-flight set is discarded, outputs clear on that edge, and inputs are ignored while `rst` is high.
- Back-to-back inputs with differing masks produce independent outputs on consecutive cycles, with no state carried between cycles.

## Test plan
- Reset: hold `rst` 2 cycles with `word_in_valid`=4'hF → outputs stay 4'b0000, all words 0, `last_input_out`=0.
- Single lane: mask 4'b0100, `word_in[2]`=64'hAAAA → next cycle `word_out_valid`=4'b1000, `word_out[0]`=64'hAAAA, slots 1..3 = 0.
- Sparse pair: mask 4'b1010, `word_in[1]`=64'h11, `word_in[3]`=64'h33 → next cycle 4'b1100, slot0=64'h11, slot1=64'h33.
- Exhaustive: sweep all 16 masks with `word_in[k]`=64'h100+k, back-to-back → each output matches ascending-lane compaction and the thermometer mask, one cycle later, with no bubbles.
- End-of-stream: mask 4'b0111 with `last_input_in`=1 for one cycle → next cycle 4'b1110 and `last_input_out`=1, both for exactly that single cycle.
- Reset mid-stream: `rst` asserted the cycle after a mask 4'b1111 input → outputs cleared on the reset edge; the 4'b1111 set is never seen after reset deasserts.
